// File: rtl/pkt_a_injector.sv
// Burst packet injector for a mesh node A-port: one command expands into len packets with seed+idx payloads.
// First a_vld one cycle after accept; a_rdy low holds the packet, and too many stall cycles abort the burst.
module pkt_a_injector #(
  parameter int HP      = 0,
  parameter int VP      = 0,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pg_en,
  input  logic [5:0]        pg_node,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [5:0]        cmd_tgt,
  input  logic              cmd_qos,
  input  logic [1:0]        cmd_type,
  input  logic [7:0]        cmd_len,
  input  logic [DATA_W-1:0] cmd_seed,
  output logic              a_vld,
  input  logic              a_rdy,
  output logic              a_qos,
  output logic [1:0]        a_type,
  output logic [5:0]        a_src,
  output logic [5:0]        a_tgt,
  output logic [DATA_W-1:0] a_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [15:0]       sent_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;

  localparam logic [5:0]  SRC_ID     = {3'(VP), 3'(HP)};
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [5:0]          tgt_q, tgt_d;
  logic                qos_q, qos_d;
  logic [1:0]          type_q, type_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [15:0]         stall_q, stall_d;
  logic [15:0]         sent_q, sent_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                xfer;

  assign xfer = (state_q == ST_SEND) && a_rdy;

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    qos_d      = qos_q;
    type_d     = type_q;
    len_d      = len_q;
    idx_d      = idx_q;
    data_d     = data_q;
    stall_d    = stall_q;
    sent_d     = sent_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_vld) begin
          // Faulty destination outranks the self-target check.
          if (pg_en && (cmd_tgt == pg_node)) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else if (cmd_tgt == SRC_ID) begin
            err_d      = 1'b1;
            err_code_d = 2'b10;
          end else if (cmd_len == 8'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SEND;
            tgt_d   = cmd_tgt;
            qos_d   = cmd_qos;
            type_d  = cmd_type;
            len_d   = cmd_len;
            data_d  = cmd_seed;
            idx_d   = 8'd0;
            stall_d = 16'd0;
          end
        end
      end
      ST_SEND: begin
        if (xfer) begin
          stall_d = 16'd0;
          idx_d   = idx_q + 8'd1;
          data_d  = data_q + DATA_W'(1);
          if (sent_q != 16'hFFFF) sent_d = sent_q + 16'd1;
          if (idx_q == len_q - 8'd1) state_d = ST_DONE;
        end else if (pg_en && (pg_node == tgt_q)) begin
          // A transfer in the same cycle wins; the abort is re-evaluated next cycle.
          state_d    = ST_IDLE;
          stall_d    = 16'd0;
          err_d      = 1'b1;
          err_code_d = 2'b01;
        end else if (stall_q == STALL_LAST) begin
          state_d    = ST_IDLE;
          stall_d    = 16'd0;
          err_d      = 1'b1;
          err_code_d = 2'b11;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tgt_q      <= '0;
      qos_q      <= 1'b0;
      type_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      stall_q    <= '0;
      sent_q     <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      qos_q      <= qos_d;
      type_q     <= type_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      stall_q    <= stall_d;
      sent_q     <= sent_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign cmd_rdy  = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign a_vld    = (state_q == ST_SEND);
  assign a_qos    = qos_q;
  assign a_type   = type_q;
  assign a_src    = SRC_ID;
  assign a_tgt    = tgt_q;
  assign a_data   = data_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign sent_cnt = sent_q;

endmodule
